systolic_ctrl: RTL and testbench

Parametrised sequencing controller for a ROWS x COLS weight-stationary systolic array. It drives per-PE mux and add-zero controls and per-column accumulator valids. On one start handshake it runs a programmable number of back-to-back tiles (load weights, then stream), then pulses done. It sits between the host/DMA front end and the PE grid and accumulator bank.

---
 rtl/systolic_pkg.sv | 11 +
 rtl/systolic_ctrl.sv | 126 ++++++++++++
 tb/tb_systolic_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array datapath and its controller.
// input_mux_t selects what each PE latches or forwards.
package systolic_pkg;

  typedef enum logic [1:0] {
    PASSTHROUGH = 2'd0,
    LOAD        = 2'd1,
    PROCESS     = 2'd2
  } input_mux_t;

endpackage

// File: rtl/systolic_ctrl.sv
// Tile sequencer for a ROWS x COLS weight-stationary systolic array.
// Ports: clk_i, rst_ni, start_i/tiles_i/abort_i in; ready_o, done_o,
// tile_idx_o, mux_o, add_zero_o, acc_valid_o out.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      tiles_i,
  input  logic                  abort_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      tile_idx_o,
  output input_mux_t [ROWS-1:0][COLS-1:0] mux_o,
  output logic [ROWS-1:0][COLS-1:0] add_zero_o,
  output logic [COLS-1:0]       acc_valid_o
);

  localparam int P  = 2*ROWS + COLS - 1;
  localparam int CW = $clog2(P + 1);

  localparam logic [CW-1:0] L_END = CW'(ROWS - 1);
  localparam logic [CW-1:0] P_END = CW'(P - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PROC = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] tile_q;
  input_mux_t       sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rem    <= '0;
      tile_q <= '0;
    end else if (abort_i && state != ST_IDLE) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rem    <= '0;
      tile_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            tile_q <= '0;
            rem    <= (tiles_i == '0) ? CNT_W'(1) : tiles_i;
          end
        end
        ST_LOAD: begin
          if (cnt == L_END) begin
            state <= ST_PROC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PROC: begin
          if (cnt == P_END) begin
            cnt <= '0;
            if (rem == CNT_W'(1)) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_LOAD;
              rem    <= rem - CNT_W'(1);
              tile_q <= tile_q + CNT_W'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ready_o    = (state == ST_IDLE);
  assign done_o     = (state == ST_DONE);
  assign tile_idx_o = tile_q;

  // Weights latch on the last load cycle; the wavefront
  // reaches column j of the bottom row ROWS+j cycles in.
  always_comb begin
    sel         = PASSTHROUGH;
    add_zero_o  = '0;
    acc_valid_o = '0;
    if (state == ST_LOAD) begin
      if (cnt == L_END) sel = systolic_pkg::LOAD;
    end else if (state == ST_PROC) begin
      sel           = PROCESS;
      add_zero_o[0] = '1;
      for (int j = 0; j < COLS; j++) begin
        acc_valid_o[j] = (int'(cnt) >= ROWS + j) &&
                         (int'(cnt) <= 2*ROWS + j - 1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        mux_o[i][j] = sel;
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: 4x4 default plus a 2x8 instance.
// Expected per-cycle outputs are queued at start; a monitor pops them.
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int R = 4;
  localparam int C = 4;
  localparam int T = 15;

  typedef struct {
    logic           rdy;
    logic           dn;
    logic [7:0]     tile;
    input_mux_t     mux;
    logic [R-1:0][C-1:0] az;
    logic [C-1:0]   acc;
  } exp_t;

  logic clk = 0;
  logic rst_n;
  logic start, abort;
  logic [7:0] tiles;
  logic ready, done;
  logic [7:0] tile_idx;
  input_mux_t [R-1:0][C-1:0] mux;
  logic [R-1:0][C-1:0] az;
  logic [C-1:0] acc;

  logic start2;
  logic [7:0] tiles2;
  logic ready2, done2;
  logic [7:0] tile_idx2;
  input_mux_t [1:0][7:0] mux2;
  logic [1:0][7:0] az2;
  logic [7:0] acc2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int done_at = -1;
  int last_tile = 0;
  int idle_tile = 0;
  bit mon_en = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_ctrl #(.ROWS(R), .COLS(C), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .tiles_i(tiles),
    .abort_i(abort), .ready_o(ready), .done_o(done),
    .tile_idx_o(tile_idx), .mux_o(mux), .add_zero_o(az),
    .acc_valid_o(acc)
  );

  systolic_ctrl #(.ROWS(2), .COLS(8), .CNT_W(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .tiles_i(tiles2),
    .abort_i(1'b0), .ready_o(ready2), .done_o(done2),
    .tile_idx_o(tile_idx2), .mux_o(mux2), .add_zero_o(az2),
    .acc_valid_o(acc2)
  );

  // Expected outputs c cycles after the start edge of an n-tile run.
  function automatic exp_t model(int c, int n, int pre);
    exp_t e;
    int k, p;
    e.rdy = 0; e.dn = 0; e.tile = 8'(pre);
    e.mux = PASSTHROUGH; e.az = '0; e.acc = '0;
    if (c == 0) begin
      e.rdy = 1;
    end else if (c == n*T + 1) begin
      e.dn = 1;
      e.tile = 8'(n - 1);
    end else begin
      e.tile = 8'((c - 1) / T);
      k = (c - 1) % T;
      if (k < R) begin
        if (k == R - 1) e.mux = LOAD;
      end else begin
        p = k - R;
        e.mux = PROCESS;
        e.az[0] = '1;
        for (int j = 0; j < C; j++)
          e.acc[j] = (p >= R + j) && (p <= 2*R + j - 1);
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit mux_ok;
    if (mon_en) begin
      if (q.size() > 0) e = q.pop_front();
      else e = model(0, 1, idle_tile);
      mux_ok = 1;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++)
          if (mux[i][j] !== e.mux) mux_ok = 0;
      checks++;
      if (ready !== e.rdy || done !== e.dn || tile_idx !== e.tile ||
          az !== e.az || acc !== e.acc || !mux_ok) begin
        failures++;
        $display("FAIL trace rel=%0d rdy=%b/%b done=%b/%b tile=%0d/%0d acc=%b/%b az=%h/%h mux_ok=%b",
                 cyc - t0, ready, e.rdy, done, e.dn, tile_idx, e.tile,
                 acc, e.acc, az, e.az, mux_ok);
      end
      if (done === 1'b1) done_at = cyc - t0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push_run(int n, int pre, int cmax);
    for (int c = 0; c <= n*T + 1 && c <= cmax; c++)
      q.push_back(model(c, n, pre));
  endtask

  task automatic begin_run(int tv, int n, int cmax);
    start = 1;
    tiles = 8'(tv);
    t0 = cyc;
    done_at = -1;
    push_run(n, last_tile, cmax);
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_ready"}, int'(ready), 1);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_tile"}, int'(tile_idx), 0);
    chk({nm, "_acc"}, int'(acc), 0);
    chk({nm, "_az"}, int'(az), 0);
    chk({nm, "_mux"}, int'(mux), 0);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; tiles = 0;
    start2 = 0; tiles2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("por");
    #3 rst_n = 1;
    step();
    mon_en = 1;

    // single tile
    step();
    begin_run(1, 1, 999);
    idle_tile = 0;
    step(); start = 0;
    repeat (17) step();
    chk("single_done_cycle", done_at, 16);
    last_tile = 0;

    // three tiles back to back
    begin_run(3, 3, 999);
    idle_tile = 2;
    step(); start = 0;
    repeat (47) step();
    chk("multi_done_cycle", done_at, 46);
    last_tile = 2;

    // zero tiles behaves as one
    begin_run(0, 1, 999);
    idle_tile = 0;
    step(); start = 0;
    repeat (17) step();
    chk("zero_done_cycle", done_at, 16);
    last_tile = 0;

    // abort in cycle 7 (PROC), restart in cycle 8
    begin_run(2, 2, 7);
    idle_tile = 0;
    step(); start = 0;
    repeat (6) step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_no_done", done_at, -1);
    begin_run(1, 1, 999);
    step(); start = 0;
    repeat (17) step();
    chk("abort_restart_done", done_at, 16);
    last_tile = 0;

    // start held high, tiles_i toggling; second run from cycle 17
    begin_run(1, 1, 999);
    push_run(2, 0, 999);
    idle_tile = 1;
    for (int r = 1; r <= 51; r++) begin
      step();
      if (r < 17) tiles = (r % 2 != 0) ? 8'd5 : 8'd0;
      else if (r == 17) tiles = 8'd2;
      else tiles = 8'd7;
      if (r == 30) start = 0;
    end
    chk("hold_done_cycle", done_at, 48);
    chk("hold_queue_drained", q.size(), 0);
    last_tile = 1;

    // async reset mid-run in cycle 10
    begin_run(3, 3, 9);
    idle_tile = 0;
    step(); start = 0;
    repeat (9) step();
    #1 rst_n = 0;
    #1 chk_reset_outs("async_rst");
    #1 rst_n = 1;
    last_tile = 0;
    repeat (3) step();
    begin_run(1, 1, 999);
    step(); start = 0;
    repeat (17) step();
    chk("post_rst_done", done_at, 16);

    // 2x8 instance: P=11, T=13
    start2 = 1; tiles2 = 8'd1;
    step(); start2 = 0;
    for (int r = 1; r <= 15; r++) begin
      chk($sformatf("sweep_acc7_c%0d", r), int'(acc2[7]),
          (r == 12 || r == 13) ? 1 : 0);
      chk($sformatf("sweep_done_c%0d", r), int'(done2),
          (r == 14) ? 1 : 0);
      step();
    end
    chk("sweep_ready_after", int'(ready2), 1);

    chk("queue_empty", q.size(), 0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
